// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and memory owner codes.
// The starvation-guard states are only used when DM_ARB_STARVE_EN is defined.
package dm_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FORCE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } owner_e;

endpackage

// File: rtl/dm_arb_wait_ctr.sv
// Saturating 4-bit wait counter for the starvation guard; hit_o flags MAX_WAIT-1.
// Compiled only when DM_ARB_STARVE_EN is defined.
`ifdef DM_ARB_STARVE_EN
module dm_arb_wait_ctr
   import dm_arb_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   localparam int              CNT_W   = 4;
   localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q == HIT_VAL);

endmodule
`endif

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and an external port.
// Define DM_ARB_STARVE_EN to add the starvation guard (forced external slot + cpu_stall).
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int AW       = 7,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ext_req,
   input  logic          ext_wr,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_gnt,
   output logic [DW-1:0] ext_rdata,
   output logic          ext_rvalid,
   output logic          dm_rd,
   output logic          dm_wr,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] dm_rdata
);

   if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
      $error("dm_arbiter: MAX_WAIT must be within 1..15");
   end

   logic   cpu_act;
   owner_e owner;
   logic   stall;

   assign cpu_act = cpu_rd | cpu_wr;

`ifdef DM_ARB_STARVE_EN
   state_e state_q;
   state_e state_d;
   logic   wait_hit;

   dm_arb_wait_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (~ext_req | ext_gnt),
      .inc_i (ext_req & ~ext_gnt),
      .hit_o (wait_hit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Checking hit from S_IDLE lets MAX_WAIT=1 force on the second waiting cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ext_req && !ext_gnt) begin
               state_d = wait_hit ? S_FORCE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!ext_req || ext_gnt) begin
               state_d = S_IDLE;
            end else if (wait_hit) begin
               state_d = S_FORCE;
            end
         end
         S_FORCE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
`endif

   // A forced slot dropped by the requester still stalls the CPU but issues no strobe.
   always_comb begin
      owner = OWN_NONE;
      stall = 1'b0;
      if (!rst_n) begin
         owner = OWN_NONE;
      end
`ifdef DM_ARB_STARVE_EN
      else if (state_q == S_FORCE) begin
         stall = cpu_act;
         if (ext_req) begin
            owner = OWN_EXT;
         end
      end
`endif
      else if (cpu_act) begin
         owner = OWN_CPU;
      end else if (ext_req) begin
         owner = OWN_EXT;
      end
   end

   always_comb begin
      ext_gnt  = 1'b0;
      dm_rd    = 1'b0;
      dm_wr    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      case (owner)
         OWN_CPU: begin
            dm_wr    = cpu_wr;
            dm_rd    = cpu_rd & ~cpu_wr;
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
         end
         OWN_EXT: begin
            ext_gnt  = 1'b1;
            dm_wr    = ext_wr;
            dm_rd    = ~ext_wr;
            dm_addr  = ext_addr;
            dm_wdata = ext_wdata;
         end
         default: ;
      endcase
   end

   logic [DW-1:0] ext_rdata_q;
   logic [DW-1:0] ext_rdata_d;
   logic          ext_rvalid_q;
   logic          ext_rvalid_d;

   assign ext_rvalid_d = ext_gnt & ~ext_wr;
   assign ext_rdata_d  = ext_rvalid_d ? dm_rdata : ext_rdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ext_rdata_q  <= '0;
         ext_rvalid_q <= 1'b0;
      end else begin
         ext_rdata_q  <= ext_rdata_d;
         ext_rvalid_q <= ext_rvalid_d;
      end
   end

   // Gating with rst_n drops the pulse of a read granted just before reset asserts.
   assign ext_rvalid = ext_rvalid_q & rst_n;
   assign ext_rdata  = ext_rdata_q;
   assign cpu_rdata  = dm_rdata;
   assign cpu_stall  = stall;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural 128x32 memory.
// Expectations follow DM_ARB_STARVE_EN when it is defined for the build.
module tb_dm_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [6:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        ext_req;
   logic        ext_wr;
   logic [6:0]  ext_addr;
   logic [31:0] ext_wdata;
   logic        ext_gnt;
   logic [31:0] ext_rdata;
   logic        ext_rvalid;
   logic        dm_rd;
   logic        dm_wr;
   logic [6:0]  dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;

   int tests_run    = 0;
   int tests_failed = 0;

   dm_arbiter #(
      .AW       (7),
      .DW       (32),
      .MAX_WAIT (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .ext_req    (ext_req),
      .ext_wr     (ext_wr),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_gnt    (ext_gnt),
      .ext_rdata  (ext_rdata),
      .ext_rvalid (ext_rvalid),
      .dm_rd      (dm_rd),
      .dm_wr      (dm_wr),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_rdata   (dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: word i preloads to 0xA5A5_0000 | i on the first clock edge.
   logic [31:0] mem [0:127];
   logic        mem_loaded = 1'b0;

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
         mem_loaded <= 1'b1;
      end else if (dm_wr) begin
         mem[dm_addr] <= dm_wdata;
      end
   end

   assign dm_rdata = mem_loaded ? mem[dm_addr] : 32'h0;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      ext_req   = 1'b0;
      ext_wr    = 1'b0;
      ext_addr  = '0;
      ext_wdata = '0;
   endtask

   task automatic test_reset();
      next_cycle();
      rst_n    = 1'b0;
      ext_req  = 1'b1;
      cpu_rd   = 1'b1;
      cpu_addr = 7'd3;
      @(negedge clk);
      tests_run++; if (ext_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0", ext_gnt); end
      tests_run++; if (dm_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_dm_rd: got %b want 0", dm_rd); end
      tests_run++; if (ext_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b want 0", ext_rvalid); end
      tests_run++; if (cpu_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
      next_cycle();
      idle_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if (ext_gnt !== 1'b0) begin tests_failed++; $display("FAIL idle_gnt: got %b want 0", ext_gnt); end
      tests_run++; if ({dm_rd, dm_wr} !== 2'b00) begin tests_failed++; $display("FAIL idle_strobes: got %b want 00", {dm_rd, dm_wr}); end
      tests_run++; if (ext_rdata !== 32'h0) begin tests_failed++; $display("FAIL idle_rdata: got %h want 0", ext_rdata); end
      tests_run++; if (cpu_stall !== 1'b0) begin tests_failed++; $display("FAIL idle_stall: got %b want 0", cpu_stall); end
   endtask

   task automatic test_ext_write_read();
      next_cycle();
      ext_req   = 1'b1;
      ext_wr    = 1'b1;
      ext_addr  = 7'd5;
      ext_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      tests_run++; if (ext_gnt !== 1'b1) begin tests_failed++; $display("FAIL wr_gnt: got %b want 1", ext_gnt); end
      tests_run++; if ({dm_wr, dm_rd} !== 2'b10) begin tests_failed++; $display("FAIL wr_strobes: got %b want 10", {dm_wr, dm_rd}); end
      tests_run++; if (dm_addr !== 7'd5) begin tests_failed++; $display("FAIL wr_addr: got %0d want 5", dm_addr); end
      next_cycle();
      ext_wr = 1'b0;
      @(negedge clk);
      tests_run++; if (ext_gnt !== 1'b1) begin tests_failed++; $display("FAIL rd_gnt: got %b want 1", ext_gnt); end
      tests_run++; if (ext_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_rvalid_early: got %b want 0", ext_rvalid); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++; if (ext_rvalid !== 1'b1) begin tests_failed++; $display("FAIL rd_rvalid: got %b want 1", ext_rvalid); end
      tests_run++; if (ext_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_data: got %h want deadbeef", ext_rdata); end
      next_cycle();
      @(negedge clk);
      tests_run++; if (ext_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_rvalid_pulse: got %b want 0", ext_rvalid); end
      tests_run++; if (ext_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_data_hold: got %h want deadbeef", ext_rdata); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_data;
      for (int k = 0; k <= 3; k++) begin
         next_cycle();
         ext_req  = (k < 3);
         ext_wr   = 1'b0;
         ext_addr = 7'(10 + k);
         @(negedge clk);
         if (k < 3) begin
            tests_run++; if (ext_gnt !== 1'b1) begin tests_failed++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, ext_gnt); end
         end
         if (k > 0) begin
            exp_data = 32'hA5A5_0000 | 32'(9 + k);
            tests_run++; if (ext_rvalid !== 1'b1) begin tests_failed++; $display("FAIL b2b_rvalid[%0d]: got %b want 1", k, ext_rvalid); end
            tests_run++; if (ext_rdata !== exp_data) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h want %h", k, ext_rdata, exp_data); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_cpu_priority();
      next_cycle();
      cpu_rd   = 1'b1;
      cpu_addr = 7'd3;
      ext_req  = 1'b1;
      ext_wr   = 1'b0;
      ext_addr = 7'd7;
      @(negedge clk);
      tests_run++; if (dm_addr !== 7'd3) begin tests_failed++; $display("FAIL prio_addr: got %0d want 3", dm_addr); end
      tests_run++; if (ext_gnt !== 1'b0) begin tests_failed++; $display("FAIL prio_gnt: got %b want 0", ext_gnt); end
      tests_run++; if (dm_rd !== 1'b1) begin tests_failed++; $display("FAIL prio_rd: got %b want 1", dm_rd); end
      tests_run++; if (cpu_rdata !== 32'hA5A5_0003) begin tests_failed++; $display("FAIL prio_rdata: got %h want a5a50003", cpu_rdata); end
      next_cycle();
      cpu_wr    = 1'b1;
      cpu_addr  = 7'd20;
      cpu_wdata = 32'h1234_5678;
      @(negedge clk);
      tests_run++; if ({dm_wr, dm_rd} !== 2'b10) begin tests_failed++; $display("FAIL rdwr_strobes: got %b want 10", {dm_wr, dm_rd}); end
      tests_run++; if (dm_wdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL rdwr_wdata: got %h want 12345678", dm_wdata); end
      next_cycle();
      cpu_wr = 1'b0;
      @(negedge clk);
      tests_run++; if (cpu_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL cpu_readback: got %h want 12345678", cpu_rdata); end
      next_cycle();
      cpu_rd = 1'b0;
      @(negedge clk);
      tests_run++; if (ext_gnt !== 1'b1) begin tests_failed++; $display("FAIL idle_slot_gnt: got %b want 1", ext_gnt); end
      tests_run++; if (dm_addr !== 7'd7) begin tests_failed++; $display("FAIL idle_slot_addr: got %0d want 7", dm_addr); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++; if (ext_rdata !== 32'hA5A5_0007) begin tests_failed++; $display("FAIL idle_slot_data: got %h want a5a50007", ext_rdata); end
   endtask

`ifdef DM_ARB_STARVE_EN
   task automatic test_starvation();
      logic       exp_hit;
      logic [6:0] exp_addr;
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         cpu_rd   = 1'b1;
         cpu_addr = 7'((k <= 9) ? k : 9);
         ext_req  = (k <= 9);
         ext_wr   = 1'b0;
         ext_addr = 7'd40;
         @(negedge clk);
         exp_hit  = (k == 9);
         exp_addr = exp_hit ? 7'd40 : 7'((k <= 9) ? k : 9);
         tests_run++; if (ext_gnt !== exp_hit) begin tests_failed++; $display("FAIL force_gnt[%0d]: got %b want %b", k, ext_gnt, exp_hit); end
         tests_run++; if (cpu_stall !== exp_hit) begin tests_failed++; $display("FAIL force_stall[%0d]: got %b want %b", k, cpu_stall, exp_hit); end
         tests_run++; if (dm_addr !== exp_addr) begin tests_failed++; $display("FAIL force_addr[%0d]: got %0d want %0d", k, dm_addr, exp_addr); end
         if (k == 10) begin
            tests_run++; if (ext_rvalid !== 1'b1) begin tests_failed++; $display("FAIL force_rvalid: got %b want 1", ext_rvalid); end
            tests_run++; if (ext_rdata !== 32'hA5A5_0028) begin tests_failed++; $display("FAIL force_data: got %h want a5a50028", ext_rdata); end
            tests_run++; if (dm_rd !== 1'b1) begin tests_failed++; $display("FAIL force_cpu_resume: got %b want 1", dm_rd); end
         end
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_drop_restart();
      logic exp_hit;
      for (int k = 1; k <= 15; k++) begin
         next_cycle();
         cpu_rd   = 1'b1;
         cpu_addr = 7'(k);
         ext_req  = (k != 4) && (k != 5) && (k <= 14);
         ext_wr   = 1'b1;
         ext_addr = 7'd50;
         @(negedge clk);
         exp_hit = (k == 14);
         tests_run++; if (ext_gnt !== exp_hit) begin tests_failed++; $display("FAIL restart_gnt[%0d]: got %b want %b", k, ext_gnt, exp_hit); end
         tests_run++; if (cpu_stall !== exp_hit) begin tests_failed++; $display("FAIL restart_stall[%0d]: got %b want %b", k, cpu_stall, exp_hit); end
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_wasted_slot();
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         cpu_rd   = 1'b1;
         cpu_addr = 7'd2;
         ext_req  = (k <= 8);
         ext_wr   = 1'b1;
         ext_addr = 7'd60;
         @(negedge clk);
         tests_run++; if (ext_gnt !== 1'b0) begin tests_failed++; $display("FAIL waste_gnt[%0d]: got %b want 0", k, ext_gnt); end
         if (k == 9) begin
            tests_run++; if (cpu_stall !== 1'b1) begin tests_failed++; $display("FAIL waste_stall: got %b want 1", cpu_stall); end
            tests_run++; if ({dm_rd, dm_wr} !== 2'b00) begin tests_failed++; $display("FAIL waste_strobes: got %b want 00", {dm_rd, dm_wr}); end
         end
         if (k == 10) begin
            tests_run++; if (cpu_stall !== 1'b0) begin tests_failed++; $display("FAIL waste_after_stall: got %b want 0", cpu_stall); end
            tests_run++; if (dm_rd !== 1'b1) begin tests_failed++; $display("FAIL waste_after_rd: got %b want 1", dm_rd); end
         end
      end
      next_cycle();
      idle_inputs();
   endtask
`else
   task automatic test_strict_priority();
      for (int k = 1; k <= 20; k++) begin
         next_cycle();
         cpu_rd   = 1'b1;
         cpu_addr = 7'(k);
         ext_req  = 1'b1;
         ext_wr   = 1'b0;
         ext_addr = 7'd40;
         @(negedge clk);
         tests_run++; if (ext_gnt !== 1'b0) begin tests_failed++; $display("FAIL strict_gnt[%0d]: got %b want 0", k, ext_gnt); end
         tests_run++; if (cpu_stall !== 1'b0) begin tests_failed++; $display("FAIL strict_stall[%0d]: got %b want 0", k, cpu_stall); end
      end
      next_cycle();
      cpu_rd = 1'b0;
      @(negedge clk);
      tests_run++; if (ext_gnt !== 1'b1) begin tests_failed++; $display("FAIL strict_idle_gnt: got %b want 1", ext_gnt); end
      tests_run++; if (dm_addr !== 7'd40) begin tests_failed++; $display("FAIL strict_idle_addr: got %0d want 40", dm_addr); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++; if (ext_rdata !== 32'hA5A5_0028) begin tests_failed++; $display("FAIL strict_data: got %h want a5a50028", ext_rdata); end
   endtask
`endif

   task automatic test_reset_kills_rvalid();
      next_cycle();
      ext_req  = 1'b1;
      ext_wr   = 1'b0;
      ext_addr = 7'd12;
      @(negedge clk);
      tests_run++; if (ext_gnt !== 1'b1) begin tests_failed++; $display("FAIL prerst_gnt: got %b want 1", ext_gnt); end
      next_cycle();
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      tests_run++; if (ext_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_rvalid: got %b want 0", ext_rvalid); end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if (ext_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata: got %h want 0", ext_rdata); end
      tests_run++; if (ext_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_rvalid_after: got %b want 0", ext_rvalid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      test_reset();
      test_ext_write_read();
      test_back_to_back();
      test_cpu_priority();
`ifdef DM_ARB_STARVE_EN
      test_starvation();
      test_drop_restart();
      test_wasted_slot();
`else
      test_strict_priority();
`endif
      test_reset_kills_rvalid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
